// File: rtl/seq_mod_arbiter_if.sv
// Bundle of requester, response, reducer and status signals for seq_mod_arbiter.
// slave: the arbiter side. master: the requesters, reducer and observers.
interface seq_mod_arbiter_if #(
  parameter int unsigned XW = 514,
  parameter int unsigned MW = 257
);
  logic          req0_valid, req1_valid;
  logic [XW-1:0] req0_x, req1_x;
  logic          req0_ready, req1_ready;
  logic          resp0_valid, resp1_valid;
  logic [MW-1:0] resp0_mod, resp1_mod;
  logic          red_start;
  logic [XW-1:0] red_x;
  logic          red_done;
  logic [MW-1:0] red_mod;
  logic          busy;

  modport slave (
    input  req0_valid, req1_valid, req0_x, req1_x, red_done, red_mod,
    output req0_ready, req1_ready, resp0_valid, resp1_valid, resp0_mod, resp1_mod,
           red_start, red_x, busy
  );

  modport master (
    output req0_valid, req1_valid, req0_x, req1_x, red_done, red_mod,
    input  req0_ready, req1_ready, resp0_valid, resp1_valid, resp0_mod, resp1_mod,
           red_start, red_x, busy
  );
endinterface

// File: rtl/seq_mod_arbiter.sv
// Round-robin arbiter that shares one mod (2^255-19) reducer between two requesters.
// Optional macro SEQ_MOD_CANON_SUB_EN adds a CANON state doing one conditional subtract of p.
module seq_mod_arbiter #(
  parameter int unsigned XW = 514,
  parameter int unsigned MW = 257
) (
  input  logic              clk,
  input  logic              rst,
  seq_mod_arbiter_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_LO,
    WAIT_HI,
`ifdef SEQ_MOD_CANON_SUB_EN
    CANON,
`endif
    RESP
  } state_e;

`ifdef SEQ_MOD_CANON_SUB_EN
  localparam logic [MW-1:0] P_MOD = (MW'(1) << 255) - MW'(19);
`endif

  state_e        state_q, state_d;
  logic          last_q, last_d;
  logic          id_q, id_d;
  logic [XW-1:0] x_q, x_d;
  logic          red_start_q, red_start_d;
  logic          resp0_valid_q, resp0_valid_d;
  logic          resp1_valid_q, resp1_valid_d;
  logic [MW-1:0] resp0_mod_q, resp0_mod_d;
  logic [MW-1:0] resp1_mod_q, resp1_mod_d;
  logic          busy_q, busy_d;
`ifdef SEQ_MOD_CANON_SUB_EN
  logic [MW-1:0] res_q, res_d;
`endif

  logic          sel1_c, ready0_c, ready1_c;
  logic          resp_load_c;
  logic [MW-1:0] resp_val_c;

  // Grant: req1 wins when alone, or on a tie when req0 was granted last.
  always_comb begin
    sel1_c   = bus.req1_valid && (!bus.req0_valid || !last_q);
    ready0_c = (state_q == IDLE) && bus.req0_valid && !sel1_c;
    ready1_c = (state_q == IDLE) && sel1_c;
  end

  always_comb begin
    state_d       = state_q;
    last_d        = last_q;
    id_d          = id_q;
    x_d           = x_q;
    red_start_d   = 1'b0;
    resp0_valid_d = 1'b0;
    resp1_valid_d = 1'b0;
    resp0_mod_d   = resp0_mod_q;
    resp1_mod_d   = resp1_mod_q;
    resp_load_c   = 1'b0;
    resp_val_c    = '0;
`ifdef SEQ_MOD_CANON_SUB_EN
    res_d         = res_q;
`endif

    case (state_q)
      IDLE: begin
        if (ready0_c || ready1_c) begin
          id_d        = sel1_c;
          last_d      = sel1_c;
          x_d         = sel1_c ? bus.req1_x : bus.req0_x;
          red_start_d = 1'b1;
          state_d     = ISSUE;
        end
      end
      ISSUE:   state_d = WAIT_LO;
      // Ignore a done level left over from an earlier (or abandoned) operation.
      WAIT_LO: if (!bus.red_done) state_d = WAIT_HI;
      WAIT_HI: begin
        if (bus.red_done) begin
`ifdef SEQ_MOD_CANON_SUB_EN
          res_d       = bus.red_mod;
          state_d     = CANON;
`else
          resp_load_c = 1'b1;
          resp_val_c  = bus.red_mod;
          state_d     = RESP;
`endif
        end
      end
`ifdef SEQ_MOD_CANON_SUB_EN
      CANON: begin
        resp_load_c = 1'b1;
        resp_val_c  = (res_q >= P_MOD) ? (res_q - P_MOD) : res_q;
        state_d     = RESP;
      end
`endif
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Response registers load on entry to RESP so data and strobe align.
    if (resp_load_c) begin
      if (id_q) begin
        resp1_valid_d = 1'b1;
        resp1_mod_d   = resp_val_c;
      end else begin
        resp0_valid_d = 1'b1;
        resp0_mod_d   = resp_val_c;
      end
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      last_q        <= 1'b1;
      id_q          <= 1'b0;
      x_q           <= '0;
      red_start_q   <= 1'b0;
      resp0_valid_q <= 1'b0;
      resp1_valid_q <= 1'b0;
      resp0_mod_q   <= '0;
      resp1_mod_q   <= '0;
      busy_q        <= 1'b0;
`ifdef SEQ_MOD_CANON_SUB_EN
      res_q         <= '0;
`endif
    end else begin
      state_q       <= state_d;
      last_q        <= last_d;
      id_q          <= id_d;
      x_q           <= x_d;
      red_start_q   <= red_start_d;
      resp0_valid_q <= resp0_valid_d;
      resp1_valid_q <= resp1_valid_d;
      resp0_mod_q   <= resp0_mod_d;
      resp1_mod_q   <= resp1_mod_d;
      busy_q        <= busy_d;
`ifdef SEQ_MOD_CANON_SUB_EN
      res_q         <= res_d;
`endif
    end
  end

  assign bus.req0_ready  = ready0_c;
  assign bus.req1_ready  = ready1_c;
  assign bus.red_start   = red_start_q;
  assign bus.red_x       = x_q;
  assign bus.resp0_valid = resp0_valid_q;
  assign bus.resp1_valid = resp1_valid_q;
  assign bus.resp0_mod   = resp0_mod_q;
  assign bus.resp1_mod   = resp1_mod_q;
  assign bus.busy        = busy_q;

endmodule
